// File: rtl/relay_session_ctrl.sv
// Relay session controller: steps mod_type through master/slave relay sessions on the 1.695 MHz tick.
// Optional build macro RELAY_SESSION_CTRL_AUTO_REARM_EN loops master sessions back to M_TX after the delay report.
module relay_session_ctrl #(
  parameter int TX_IDLE_TICKS    = 64,
  parameter int RESP_TIMEOUT     = 4096,
  parameter int DELAY_HOLD       = 131088,
  parameter int SLAVE_IDLE_TICKS = 256
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_mode,
  output logic       cmd_ready,
  input  logic       ssp_dout,
  input  logic       data_in,
  output logic [2:0] mod_type,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_M_TX     = 3'd1,
    ST_M_RESP   = 3'd2,
    ST_M_REPORT = 3'd3,
    ST_S_RUN    = 3'd4
  } state_t;

  localparam logic [17:0] L_TX_IDLE_LAST    = 18'(TX_IDLE_TICKS - 1);
  localparam logic [17:0] L_RESP_LAST       = 18'(RESP_TIMEOUT - 1);
  localparam logic [17:0] L_HOLD_LAST       = 18'(DELAY_HOLD - 1);
  localparam logic [17:0] L_SLAVE_IDLE_LAST = 18'(SLAVE_IDLE_TICKS - 1);

  localparam logic [1:0] CMD_MASTER = 2'b00;
  localparam logic [1:0] CMD_SLAVE  = 2'b01;
  localparam logic [1:0] CMD_ABORT  = 2'b10;

  localparam logic [2:0] MOD_MASTER = 3'b000;
  localparam logic [2:0] MOD_SLAVE  = 3'b001;
  localparam logic [2:0] MOD_DELAY  = 3'b010;
  localparam logic [2:0] MOD_OFF    = 3'b111;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_div;
  logic        w_tick;
  logic [17:0] r_cnt, w_cnt_nxt;
  logic        r_seen_high, w_seen_high_nxt;
  logic        r_pend_valid, w_pend_valid_nxt;
  logic [1:0]  r_pend_mode, w_pend_mode_nxt;
  logic        w_abort;
  logic [19:0] w_step;
  logic        w_done_nxt, w_timeout_nxt;
  logic [2:0]  r_mod_type, w_mod_type_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, r_timeout;
  logic        r_cmd_ready, w_cmd_ready_nxt;

  // Idle detector step: returns {end, seen_high, cnt}; a high line restarts the low-run count.
  function automatic logic [19:0] idle_step(input logic seen, input logic line,
                                            input logic [17:0] cnt, input logic [17:0] last);
    logic [19:0] res;
    if (line)             res = {1'b0, 1'b1, 18'd0};
    else if (!seen)       res = {1'b0, 1'b0, cnt};
    else if (cnt == last) res = {1'b1, 1'b1, cnt};
    else                  res = {1'b0, 1'b1, cnt + 18'd1};
    return res;
  endfunction

  assign w_tick    = (r_div == 3'b011);
  assign w_abort   = r_pend_valid && (r_pend_mode == CMD_ABORT);
  assign mod_type  = r_mod_type;
  assign busy      = r_busy;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign cmd_ready = r_cmd_ready;

  always_ff @(posedge ck_1356meg or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_div        <= 3'd0;
      r_cnt        <= 18'd0;
      r_seen_high  <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_mode  <= 2'b00;
      r_mod_type   <= MOD_OFF;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_cmd_ready  <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_div        <= r_div + 3'd1;
      r_cnt        <= w_cnt_nxt;
      r_seen_high  <= w_seen_high_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_mode  <= w_pend_mode_nxt;
      r_mod_type   <= w_mod_type_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_timeout    <= w_timeout_nxt;
      r_cmd_ready  <= w_cmd_ready_nxt;
    end
  end

  // Abort always wins the pending slot; a start is only taken while ready.
  always_comb begin
    w_pend_valid_nxt = w_tick ? 1'b0 : r_pend_valid;
    w_pend_mode_nxt  = r_pend_mode;
    if (cmd_valid && (cmd_mode == CMD_ABORT)) begin
      w_pend_valid_nxt = 1'b1;
      w_pend_mode_nxt  = CMD_ABORT;
    end else if (cmd_valid && r_cmd_ready && (cmd_mode != 2'b11)) begin
      w_pend_valid_nxt = 1'b1;
      w_pend_mode_nxt  = cmd_mode;
    end else begin
      w_pend_mode_nxt  = r_pend_mode;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_seen_high_nxt = r_seen_high;
    w_done_nxt      = 1'b0;
    w_timeout_nxt   = 1'b0;
    w_step          = 20'd0;
    if (!w_tick) begin
      w_state_nxt = r_state;
    end else if (w_abort) begin
      w_state_nxt     = ST_IDLE;
      w_cnt_nxt       = 18'd0;
      w_seen_high_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pend_valid && (r_pend_mode == CMD_MASTER)) begin
            w_state_nxt = ST_M_TX;
          end else if (r_pend_valid && (r_pend_mode == CMD_SLAVE)) begin
            w_state_nxt = ST_S_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
          w_cnt_nxt       = 18'd0;
          w_seen_high_nxt = 1'b0;
        end
        ST_M_TX: begin
          // Until the ARM starts talking, the counter doubles as the response timeout.
          if (!r_seen_high && !ssp_dout) begin
            if (r_cnt == L_RESP_LAST) begin
              w_state_nxt   = ST_IDLE;
              w_cnt_nxt     = 18'd0;
              w_timeout_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 18'd1;
            end
          end else begin
            w_step          = idle_step(r_seen_high, ssp_dout, r_cnt, L_TX_IDLE_LAST);
            w_seen_high_nxt = w_step[18];
            w_cnt_nxt       = w_step[17:0];
            if (w_step[19]) begin
              w_state_nxt     = ST_M_RESP;
              w_cnt_nxt       = 18'd0;
              w_seen_high_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_M_TX;
            end
          end
        end
        ST_M_RESP: begin
          if (data_in) begin
            w_state_nxt = ST_M_REPORT;
            w_cnt_nxt   = 18'd0;
          end else if (r_cnt == L_RESP_LAST) begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = 18'd0;
            w_timeout_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 18'd1;
          end
        end
        ST_M_REPORT: begin
          if (r_cnt == L_HOLD_LAST) begin
`ifdef RELAY_SESSION_CTRL_AUTO_REARM_EN
            w_state_nxt = ST_M_TX;
`else
            w_state_nxt = ST_IDLE;
`endif
            w_cnt_nxt       = 18'd0;
            w_seen_high_nxt = 1'b0;
            w_done_nxt      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 18'd1;
          end
        end
        ST_S_RUN: begin
          w_step          = idle_step(r_seen_high, data_in, r_cnt, L_SLAVE_IDLE_LAST);
          w_seen_high_nxt = w_step[18];
          w_cnt_nxt       = w_step[17:0];
          if (w_step[19]) begin
            w_state_nxt     = ST_IDLE;
            w_cnt_nxt       = 18'd0;
            w_seen_high_nxt = 1'b0;
            w_done_nxt      = 1'b1;
          end else begin
            w_state_nxt = ST_S_RUN;
          end
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_cnt_nxt       = 18'd0;
          w_seen_high_nxt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_cmd_ready_nxt = (w_state_nxt == ST_IDLE) && !w_pend_valid_nxt;
    case (w_state_nxt)
      ST_M_TX:     w_mod_type_nxt = MOD_MASTER;
      ST_M_RESP:   w_mod_type_nxt = MOD_MASTER;
      ST_M_REPORT: w_mod_type_nxt = MOD_DELAY;
      ST_S_RUN:    w_mod_type_nxt = MOD_SLAVE;
      default:     w_mod_type_nxt = MOD_OFF;
    endcase
  end

endmodule

// File: tb/tb_relay_session_ctrl.sv
// Directed bench for relay_session_ctrl with shortened tick parameters.
module tb_relay_session_ctrl;
  localparam int TXI = 8;
  localparam int RT  = 64;
  localparam int DH  = 40;
  localparam int SI  = 16;
`ifdef RELAY_SESSION_CTRL_AUTO_REARM_EN
  localparam logic [2:0] MOD_AFTER_REPORT  = 3'b000;
  localparam logic       BUSY_AFTER_REPORT = 1'b1;
`else
  localparam logic [2:0] MOD_AFTER_REPORT  = 3'b111;
  localparam logic       BUSY_AFTER_REPORT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_mode = 2'b11;
  logic       ssp_dout = 1'b0;
  logic       data_in = 1'b0;
  logic       cmd_ready, busy, done, timeout;
  logic [2:0] mod_type;
  logic [2:0] tb_div;
  logic [2:0] mon_prev;
  logic       mon_tick;
  int         checks = 0;
  int         failures = 0;

  relay_session_ctrl #(.TX_IDLE_TICKS(TXI), .RESP_TIMEOUT(RT), .DELAY_HOLD(DH), .SLAVE_IDLE_TICKS(SI)) dut (
    .ck_1356meg(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode), .cmd_ready(cmd_ready),
    .ssp_dout(ssp_dout), .data_in(data_in), .mod_type(mod_type), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Bench copy of the tick phase: free-running 3-bit count cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tb_div <= 3'd0;
    else       tb_div <= tb_div + 3'd1;
  end

  // Any clocked change of mod_type must land on a tick edge.
  always @(posedge clk) begin
    mon_prev = mod_type;
    mon_tick = (tb_div == 3'd3) && !reset;
    #1;
    if (!reset && mod_type !== mon_prev) begin
      checks++;
      if (!mon_tick) begin failures++; $display("FAIL mod_align: mod_type %b->%b on non-tick edge", mon_prev, mod_type); end
    end
  end

  task automatic tick();
    @(posedge clk);
    while (tb_div != 3'd3) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] m);
    @(negedge clk); cmd_valid = 1'b1; cmd_mode = m;
    @(negedge clk); cmd_valid = 1'b0; cmd_mode = 2'b11;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({mod_type, busy, done, timeout, cmd_ready} !== {3'b111, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL reset_values: got mod=%b busy=%b done=%b to=%b rdy=%b", mod_type, busy, done, timeout, cmd_ready); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_master();
    send_cmd(2'b00);
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL cmd_ready_drop: got %b expected 0", cmd_ready); end
    tick();
    checks++; if ({mod_type, busy} !== {3'b000, 1'b1}) begin failures++; $display("FAIL master_entry: mod=%b busy=%b expected 000/1", mod_type, busy); end
    ssp_dout = 1'b1; repeat (5) tick();
    ssp_dout = 1'b0; repeat (TXI - 1) tick();
    data_in = 1'b1; tick(); data_in = 1'b0;
    checks++; if (mod_type !== 3'b000) begin failures++; $display("FAIL tx_ignores_data: mod=%b expected 000", mod_type); end
    repeat (9) tick();
    checks++; if (mod_type !== 3'b000) begin failures++; $display("FAIL resp_wait: mod=%b expected 000", mod_type); end
    data_in = 1'b1; tick(); data_in = 1'b0;
    checks++; if (mod_type !== 3'b010) begin failures++; $display("FAIL report_entry: mod=%b expected 010", mod_type); end
    for (int i = 1; i < DH; i++) begin
      tick();
      checks++; if ({mod_type, done} !== {3'b010, 1'b0}) begin failures++; $display("FAIL report_hold: tick %0d mod=%b done=%b expected 010/0", i, mod_type, done); end
    end
    tick();
    checks++; if ({mod_type, done, timeout, busy} !== {MOD_AFTER_REPORT, 1'b1, 1'b0, BUSY_AFTER_REPORT}) begin
      failures++; $display("FAIL report_end: mod=%b done=%b to=%b busy=%b expected %b/1/0/%b", mod_type, done, timeout, busy, MOD_AFTER_REPORT, BUSY_AFTER_REPORT); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_width: got %b expected 0", done); end
    send_cmd(2'b10); tick();
    checks++; if ({mod_type, cmd_ready} !== {3'b111, 1'b1}) begin failures++; $display("FAIL master_idle: mod=%b rdy=%b expected 111/1", mod_type, cmd_ready); end
  endtask

  task automatic test_tx_timeout();
    send_cmd(2'b00); tick();
    for (int i = 1; i < RT; i++) begin
      tick();
      checks++; if ({mod_type, timeout, done} !== {3'b000, 1'b0, 1'b0}) begin failures++; $display("FAIL tx_wait: tick %0d mod=%b to=%b done=%b", i, mod_type, timeout, done); end
    end
    tick();
    checks++; if ({mod_type, timeout, done, busy} !== {3'b111, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL tx_timeout: mod=%b to=%b done=%b busy=%b expected 111/1/0/0", mod_type, timeout, done, busy); end
    @(posedge clk); #1;
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_width: got %b expected 0", timeout); end
  endtask

  task automatic test_resp_timeout();
    send_cmd(2'b00); tick();
    ssp_dout = 1'b1; tick(); ssp_dout = 1'b0;
    repeat (TXI) tick();
    repeat (RT - 1) tick();
    checks++; if ({mod_type, timeout} !== {3'b000, 1'b0}) begin failures++; $display("FAIL resp_pre_timeout: mod=%b to=%b expected 000/0", mod_type, timeout); end
    tick();
    checks++; if ({mod_type, timeout, done} !== {3'b111, 1'b1, 1'b0}) begin failures++; $display("FAIL resp_timeout: mod=%b to=%b done=%b expected 111/1/0", mod_type, timeout, done); end
  endtask

  task automatic test_resp_tie_and_abort();
    send_cmd(2'b00); tick();
    ssp_dout = 1'b1; tick(); ssp_dout = 1'b0;
    repeat (TXI) tick();
    repeat (RT - 1) tick();
    data_in = 1'b1; tick(); data_in = 1'b0;
    checks++; if ({mod_type, timeout} !== {3'b010, 1'b0}) begin failures++; $display("FAIL resp_tie: mod=%b to=%b expected 010/0", mod_type, timeout); end
    repeat (5) tick();
    send_cmd(2'b10); tick();
    checks++; if ({mod_type, done, timeout, busy} !== {3'b111, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL abort_report: mod=%b done=%b to=%b busy=%b expected 111/0/0/0", mod_type, done, timeout, busy); end
  endtask

  task automatic test_slave();
    send_cmd(2'b01); tick();
    checks++; if ({mod_type, busy} !== {3'b001, 1'b1}) begin failures++; $display("FAIL slave_entry: mod=%b busy=%b expected 001/1", mod_type, busy); end
    repeat (RT + 8) tick();
    checks++; if ({mod_type, timeout} !== {3'b001, 1'b0}) begin failures++; $display("FAIL slave_no_timeout: mod=%b to=%b expected 001/0", mod_type, timeout); end
    for (int i = 0; i < 40; i++) begin
      data_in = (i % 3 != 2);
      tick();
      checks++; if ({mod_type, done} !== {3'b001, 1'b0}) begin failures++; $display("FAIL slave_toggle: tick %0d mod=%b done=%b", i, mod_type, done); end
    end
    data_in = 1'b1; tick(); data_in = 1'b0;
    repeat (SI - 1) tick();
    checks++; if ({mod_type, done} !== {3'b001, 1'b0}) begin failures++; $display("FAIL slave_pre_end: mod=%b done=%b expected 001/0", mod_type, done); end
    tick();
    checks++; if ({mod_type, done, busy} !== {3'b111, 1'b1, 1'b0}) begin failures++; $display("FAIL slave_end: mod=%b done=%b busy=%b expected 111/1/0", mod_type, done, busy); end
  endtask

  task automatic test_start_then_abort();
    tick();
    send_cmd(2'b00);
    send_cmd(2'b10);
    tick();
    checks++; if ({mod_type, busy, cmd_ready} !== {3'b111, 1'b0, 1'b1}) begin
      failures++; $display("FAIL start_abort: mod=%b busy=%b rdy=%b expected 111/0/1", mod_type, busy, cmd_ready); end
    repeat (3) tick();
    checks++; if ({mod_type, done, timeout} !== {3'b111, 1'b0, 1'b0}) begin failures++; $display("FAIL start_discarded: mod=%b done=%b to=%b", mod_type, done, timeout); end
  endtask

  task automatic test_ignored_cmd();
    send_cmd(2'b11);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL cmd11_ready: got %b expected 1", cmd_ready); end
    tick();
    checks++; if ({mod_type, busy} !== {3'b111, 1'b0}) begin failures++; $display("FAIL cmd11_idle: mod=%b busy=%b expected 111/0", mod_type, busy); end
  endtask

  task automatic test_reset_mid();
    send_cmd(2'b01); tick();
    data_in = 1'b1; repeat (3) tick();
    @(negedge clk); reset = 1'b1; #1;
    checks++; if ({mod_type, busy, done} !== {3'b111, 1'b0, 1'b0}) begin failures++; $display("FAIL reset_mid: mod=%b busy=%b done=%b expected 111/0/0", mod_type, busy, done); end
    @(negedge clk); reset = 1'b0; data_in = 1'b0; #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    tick();
    checks++; if (mod_type !== 3'b111) begin failures++; $display("FAIL reset_stays_idle: mod=%b expected 111", mod_type); end
  endtask

  initial begin
    test_reset();
    test_master();
    test_tx_timeout();
    test_resp_timeout();
    test_resp_tie_and_abort();
    test_slave();
    test_start_then_abort();
    test_ignored_cmd();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/relay_session_ctrl.md
Name: relay_session_ctrl

Overview:
Sequences the relay datapath's mode input (mod_type) through complete relay sessions. Sits between the ARM command interface and the relay block, clocked by the 13.56 MHz carrier clock.
- Master session: forward the ARM frame, wait for the peer's response, then hold DELAY mode long enough for the delay word to reach the ARM.
- Slave session: hold SLAVE mode until the peer link goes idle.
- Mode changes are aligned to the relay's 1.695 MHz tick so the relay never samples a changing mode.

Parameters:
TX_IDLE_TICKS, 64, consecutive low ssp_dout ticks (after first high) that end the ARM frame
RESP_TIMEOUT, 4096, ticks allowed in M_TX before first ssp_dout high, and in M_RESP before data_in high
DELAY_HOLD, 131088, ticks spent in DELAY mode (2^17 + 16, one full delay-report cycle)
SLAVE_IDLE_TICKS, 256, consecutive low data_in ticks (after first high) that end a slave session

Ports:
ck_1356meg  in   1  13.56 MHz clock
reset       in   1  asynchronous, active-high reset
cmd_valid   in   1  one-clock command strobe from ARM
cmd_mode    in   2  00 start master session, 01 start slave session, 10 abort, 11 ignored
cmd_ready   out  1  high in IDLE with no pending command
ssp_dout    in   1  ARM transmit bit (monitored only)
data_in     in   1  line from peer Proxmark (monitored only)
mod_type    out  3  to relay: 000 MASTER, 001 SLAVE, 010 DELAY, 111 OFF
busy        out  1  high in any state except IDLE
done        out  1  one-clock pulse on normal session end
timeout     out  1  one-clock pulse on timeout end

Behaviour:
- Reset values:
  - mod_type=111, busy=0, done=0, timeout=0, cmd_ready=1.
  - State IDLE; divider, counters, pending and seen_high cleared.
- Tick:
  - 3-bit free-running divider; tick = (div==3'b011), one clock before the relay samples at 3'b100.
  - All state transitions, mod_type updates and counter steps happen only on tick clocks.
  - done/timeout pulse on the tick clock only.
- Command capture:
  - cmd_valid is captured on any clock into a pending register (mode plus valid).
  - A start command is captured only when cmd_ready=1.
  - Abort is captured in any state and overwrites a pending start.
  - Pending is consumed at the next tick.
  - cmd_ready drops the clock after capture.
- States and mod_type:
  - IDLE (111): pending 00 -> M_TX; pending 01 -> S_RUN.
  - M_TX (000): cnt counts ticks.
    - Before the first ssp_dout high, cnt==RESP_TIMEOUT-1 -> IDLE with timeout.
    - A high tick sets seen_high and clears cnt.
    - After seen_high, a low tick increments cnt and a high tick clears it; cnt==TX_IDLE_TICKS-1 on a low tick -> M_RESP.
  - M_RESP (000): data_in high on tick -> M_REPORT. Otherwise cnt==RESP_TIMEOUT-1 -> IDLE with timeout. If both occur on the same tick, data_in wins.
  - M_REPORT (010): cnt==DELAY_HOLD-1 -> IDLE with done.
  - S_RUN (001): same idle-detect rule as M_TX, applied to data_in with SLAVE_IDLE_TICKS -> IDLE with done. No timeout.
  - Abort pending in any state -> IDLE, mod_type 111, no done/timeout. Abort while IDLE clears pending only.
- Counter:
  - cnt is 18 bits and cleared on every state entry.
  - Parameters must be <= 2^18; cnt never wraps.
- Reset mid-session: immediate return to reset values. mod_type=111 is asynchronous with reset.
- busy equals (state != IDLE) as a registered output, updated with the state.

Optional Feature:
RELAY_SESSION_CTRL_AUTO_REARM_EN:
- Defined: on M_REPORT completion, done pulses and the state goes to M_TX (mod_type 000, counters and seen_high cleared). This loops until abort. Timeout still returns to IDLE.
- Undefined: M_REPORT completion goes to IDLE.

Test Plan:
- Reset asserted mid-S_RUN -> mod_type=111, busy=0 on the same cycle; cmd_ready=1 after release.
- cmd 00; ssp_dout high 5 ticks then low; data_in high 10 ticks after M_RESP entry -> mod_type 000 until M_REPORT, 010 for exactly 131088 ticks, then 111 and one done pulse. All mod_type edges fall on clocks with div==3'b011.
- cmd 00; ssp_dout stays low -> timeout pulse after 4096 ticks, mod_type=111, done never asserted.
- cmd 01 with data_in toggling for 1000 ticks, then low -> done exactly 256 ticks after the last high tick, mod_type 001 throughout.
- Abort issued in M_REPORT; start issued in the same cycle as an abort -> IDLE with no done/timeout, and the start is discarded.
- With RELAY_SESSION_CTRL_AUTO_REARM_EN defined and DELAY_HOLD=32: two consecutive master sessions -> two done pulses, mod_type 010 -> 000 with no 111 in between.
